spram_burst_initiator: RTL
==========================

// Module: spram_burst_initiator
// PURPOSE
// Initiator for the 32x8 banked single-port RAM port (en/we/addr/din/dout). Accepts
// one burst command (read or write, start address, length), streams write data in
// or read data out over valid/ready, generates the per-beat RAM strobes, and pulses
// done on completion. Sits between the AXI front end and the banked RAM.
// PARAMETERS
// ADDR_W  5  RAM address width; addresses wrap modulo 2**ADDR_W
// DATA_W  8  RAM / stream data width
// LEN_W   6  burst length width, beats = cmd_len (0..63)
// PORTS
// clk        in   1       clock, all logic on rising edge
// rst        in   1       synchronous reset, active high
// cmd_valid  in   1       command offered
// cmd_ready  out  1       command accepted when cmd_valid&cmd_ready
// cmd_write  in   1       1 = write burst, 0 = read burst
// cmd_addr   in   ADDR_W  start address
// cmd_len    in   LEN_W   number of beats
// wr_valid   in   1       write beat offered
// wr_ready   out  1       write beat accepted
// wr_data    in   DATA_W  write beat data
// rd_valid   out  1       read beat offered
// rd_ready   in   1       read beat accepted
// rd_data    out  DATA_W  read beat data
// done       out  1       one-cycle pulse, burst complete
// mem_en     out  1       RAM enable
// mem_we     out  1       RAM write enable
// mem_addr   out  ADDR_W  RAM address
// mem_din    out  DATA_W  RAM write data
// mem_dout   in   DATA_W  RAM read data, valid 1 cycle after mem_en&!mem_we
// BEHAVIOUR
// - Reset: state IDLE; cmd_ready/wr_ready/rd_valid/done/mem_en/mem_we=0; mem_addr,
//   mem_din, rd_data=0; counters, in-flight flag, read buffer cleared. cmd_ready=1
//   first cycle after rst deasserts. Reset mid-burst aborts it; no done.
// - FSM: IDLE -> WRITE (cmd_write=1, len>0), READ (cmd_write=0, len>0), DONE (len=0).
//   WRITE -> DONE after last write handshake. READ -> DONE after last rd handshake.
//   DONE -> IDLE unconditionally (done=1 for exactly this cycle). cmd_ready=1 only in IDLE.
// - Command fields captured on accept; cur_addr=cmd_addr, remaining=cmd_len.
// - WRITE: wr_ready=1 throughout state. Beat on wr_valid&wr_ready: same cycle
//   mem_en=1, mem_we=1, mem_addr=cur_addr, mem_din=wr_data (combinational);
//   cur_addr+1 mod 2**ADDR_W, remaining-1. No handshake -> mem_en=0. Max 1 beat/cycle.
// - READ: 2-entry output FIFO; issue read (mem_en=1, mem_we=0, mem_addr=cur_addr)
//   when issued<len and fifo_count+inflight<2. mem_dout captured into FIFO the
//   following cycle. rd_valid=fifo not empty; rd_data=FIFO head. Full throughput
//   (1 beat/cycle) with rd_ready held high; first rd_valid 2 cycles after cmd accept.
// - Backpressure: rd_ready low never drops or duplicates data; reads stall at 2 held.
// - Simultaneous FIFO push/pop same cycle: count unchanged, order preserved.
// - Address wrap: 31 -> 0, crossing bank boundaries transparently; len>32 legal,
//   revisits addresses modulo 32.
// - cmd_valid while not IDLE: ignored (cmd_ready=0), command held by sender.
// - wr_valid outside WRITE / rd_ready outside READ: ignored, no RAM access.
// TESTING
// 1. rst; write addr=6 len=4 data AA,BB,CC,DD, wr_valid held -> mem_en&mem_we 4
//    consecutive cycles at addr 6,7,8,9; done pulses 1 cycle after last beat.
// 2. Read addr=6 len=4, rd_ready=1 -> rd_data AA,BB,CC,DD on 4 consecutive cycles
//    starting 2 cycles after accept; done 1 cycle after last handshake.
// 3. Write addr=30 len=4 data 11,22,33,44 -> mem_addr 30,31,0,1; read back addr=30
//    len=4 returns 11,22,33,44.
// 4. Read len=8 with rd_ready low 5 cycles mid-burst -> at most 2 reads issued
//    ahead, rd_valid held, all 8 beats delivered in order, no duplicates.
// 5. Write len=3 with wr_valid 1,0,0,1,1 -> mem_en only on 3 handshake cycles,
//    addresses consecutive; len=0 command -> done next cycle, no mem_en.
// 6. rst asserted during READ beat 2 of 6 -> next cycle rd_valid=0, mem_en=0,
//    done=0, cmd_ready=1 after release; new command executes correctly.

Source files
------------

// File: rtl/spram_burst_initiator.sv
// Burst initiator for the banked single-port RAM: takes one read/write burst command,
// streams beats over valid/ready and drives the per-beat RAM strobes.
module spram_burst_initiator #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_done,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  input  logic [DATA_W-1:0] i_mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  r_issue_left;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_cmd_fire;
  logic              w_first_rd;
  logic              w_wr_fire;
  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_occ;
  logic              w_rd_issue;

  assign w_cmd_fire = i_cmd_valid && (r_state == S_IDLE) && !i_rst;
  // The first read goes out in the accept cycle so data is offered two cycles later.
  assign w_first_rd = w_cmd_fire && !i_cmd_write && (i_cmd_len != '0);
  assign w_wr_fire  = (r_state == S_WRITE) && i_wr_valid;
  assign w_pop      = (r_state == S_READ) && (r_count != 2'd0) && i_rd_ready;
  assign w_push     = r_inflight;
  // Occupancy after this cycle's pop; counting the pop keeps one beat per cycle.
  assign w_occ      = r_count + 2'(r_inflight) - 2'(w_pop);
  assign w_rd_issue = (r_state == S_READ) && (r_issue_left != '0) && (w_occ < 2'd2);

  assign o_rd_valid = (r_count != 2'd0);
  assign o_rd_data  = r_fifo[r_rptr];

  always_comb begin
    w_next      = r_state;
    o_cmd_ready = 1'b0;
    o_wr_ready  = 1'b0;
    o_done      = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = r_cur_addr;
    o_mem_din   = '0;
    case (r_state)
      S_IDLE: begin
        o_cmd_ready = !i_rst;
        if (w_cmd_fire) begin
          if (i_cmd_len == '0) begin
            w_next = S_DONE;
          end else if (i_cmd_write) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_READ;
          end
        end
        if (w_first_rd) begin
          o_mem_en   = 1'b1;
          o_mem_addr = i_cmd_addr;
        end
      end
      S_WRITE: begin
        o_wr_ready = 1'b1;
        if (w_wr_fire) begin
          o_mem_en  = 1'b1;
          o_mem_we  = 1'b1;
          o_mem_din = i_wr_data;
          if (r_remaining == LEN_W'(1)) begin
            w_next = S_DONE;
          end
        end
      end
      S_READ: begin
        o_mem_en = w_rd_issue;
        if (w_pop && (r_remaining == LEN_W'(1))) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_issue_left <= '0;
      r_inflight   <= 1'b0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_count      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      r_state    <= w_next;
      r_inflight <= w_first_rd || w_rd_issue;
      if (w_cmd_fire) begin
        r_remaining  <= i_cmd_len;
        r_cur_addr   <= w_first_rd ? i_cmd_addr + ADDR_W'(1) : i_cmd_addr;
        r_issue_left <= w_first_rd ? i_cmd_len - LEN_W'(1) : '0;
      end
      if (w_wr_fire) begin
        r_cur_addr  <= r_cur_addr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
      if (w_rd_issue) begin
        r_cur_addr   <= r_cur_addr + ADDR_W'(1);
        r_issue_left <= r_issue_left - LEN_W'(1);
      end
      if (w_pop) begin
        r_remaining <= r_remaining - LEN_W'(1);
        r_rptr      <= ~r_rptr;
      end
      if (w_push) begin
        r_fifo[r_wptr] <= i_mem_dout;
        r_wptr         <= ~r_wptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule
